pipelined_shifter: RTL and testbench

Parametrised, fully pipelined barrel shifter for the ALU datapath. It generalises the 16-bit arithmetic-right shifter to any power-of-two width.
- Supports four modes: SLL, SRL, SRA and ROR.
- Uses one register stage per shift-amount bit.
- Uses a valid/ready handshake with full-pipeline back-pressure.
- Carries a sideband tag alongside each operand so the issue logic can match results to instructions.

---
 rtl/pipelined_shifter.sv | 106 ++++++++++
 tb/tb_pipelined_shifter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(WIDTH)-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready and sideband tag.
// Optional out_zero/out_neg flag outputs are enabled by defining SHIFTER_FLAGS_EN.
module pipelined_shifter #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);
  logic             adv;
  logic [SHW-1:0]   vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [SHW];
  logic [WIDTH-1:0] dat_d [SHW];
  logic [WIDTH-1:0] src_dat [SHW];
  logic [TAG_W-1:0] tg_q [SHW];
  logic [TAG_W-1:0] tg_d [SHW];
  logic [SHW-1:0]   src_sh [SHW];
  logic [1:0]       src_md [SHW];
  // Shamt is kept right-aligned: each stage consumes bit 0 and forwards the rest.
  logic [SHW-1:0]   sh_q [SHW-1];
  logic [1:0]       md_q [SHW-1];

  function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] v, input logic [1:0] m, input int s);
    logic [WIDTH-1:0] sra;
    sra = $signed(v) >>> s;
    return m == 2'd0 ? v << s : m == 2'd1 ? v >> s : m == 2'd2 ? sra : (v >> s) | (v << (WIDTH - s));
  endfunction

  assign adv       = !vld_q[SHW-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[SHW-1];
  assign out_data  = dat_q[SHW-1];
  assign out_tag   = tg_q[SHW-1];

  always_comb begin
    vld_d[0]   = in_valid & adv;
    src_dat[0] = in_data;
    src_sh[0]  = in_shamt;
    src_md[0]  = in_mode;
    tg_d[0]    = in_tag;
    for (int k = 1; k < SHW; k++) begin
      vld_d[k]   = vld_q[k-1];
      src_dat[k] = dat_q[k-1];
      src_sh[k]  = sh_q[k-1];
      src_md[k]  = md_q[k-1];
      tg_d[k]    = tg_q[k-1];
    end
    for (int k = 0; k < SHW; k++)
      dat_d[k] = src_sh[k][0] ? shf(src_dat[k], src_md[k], 1 << k) : src_dat[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        dat_q[k] <= '0;
        tg_q[k]  <= '0;
      end
      for (int k = 0; k < SHW - 1; k++) begin
        sh_q[k] <= '0;
        md_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      for (int k = 0; k < SHW; k++) begin
        dat_q[k] <= dat_d[k];
        tg_q[k]  <= tg_d[k];
      end
      for (int k = 0; k < SHW - 1; k++) begin
        sh_q[k] <= src_sh[k] >> 1;
        md_q[k] <= src_md[k];
      end
    end
  end

`ifdef SHIFTER_FLAGS_EN
  logic zero_q, neg_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else if (adv) begin
      zero_q <= dat_d[SHW-1] == '0;
      neg_q  <= dat_d[SHW-1][WIDTH-1];
    end
  end
  assign out_zero = zero_q;
  assign out_neg  = neg_q;
`endif
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed + random scoreboard bench for pipelined_shifter (WIDTH=16).
module tb_pipelined_shifter;
  localparam int W = 16, TW = 4, SW = 4;
  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0]  in_data = '0, out_data;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0, out_tag;
`ifdef SHIFTER_FLAGS_EN
  logic          out_zero, out_neg;
`endif

  pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef SHIFTER_FLAGS_EN
    , .out_zero(out_zero), .out_neg(out_neg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [W-1:0] d; logic [TW-1:0] t;} exp_t;
  exp_t q[$];
  exp_t e;
  int passes = 0, checks = 0;
  logic [W-1:0]  held_d;
  logic [TW-1:0] held_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m);
    logic signed [W-1:0] sd;
    logic [2*W-1:0] dd;
    sd = d;
    dd = {d, d} >> s;
    case (m)
      2'd0: return d << s;
      2'd1: return d >> s;
      2'd2: return sd >>> s;
      default: return dd[W-1:0];
    endcase
  endfunction

  always @(negedge clk) if (!rst) begin
    if (out_valid && out_ready) begin
      chk("q_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("tag", 32'(out_tag), 32'(e.t));
`ifdef SHIFTER_FLAGS_EN
        chk("zero", 32'(out_zero), 32'(e.d == '0));
        chk("neg", 32'(out_neg), 32'(e.d[W-1]));
`endif
      end
    end
    if (in_valid && in_ready) q.push_back({model(in_data, in_shamt, in_mode), in_tag});
  end

  task automatic set_in(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m, input logic [TW-1:0] t);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m; in_tag = t;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m, input logic [TW-1:0] t);
    int n = 0;
    set_in(d, s, m, t);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
`ifdef SHIFTER_FLAGS_EN
    chk("rst_zero", 32'(out_zero), 1);
    chk("rst_neg", 32'(out_neg), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    // latency: accepted at edge N, visible after edge N+3
    set_in(16'h8000, 4'd4, 2'd2, 4'h5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 0);
    end
    @(negedge clk);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h0000F800);
    @(posedge clk); #1;
    idle(2);
    send(16'h0001, 4'd15, 2'd0, 4'h1);
    send(16'h8000, 4'd15, 2'd1, 4'h2);
    send(16'h1234, 4'd4,  2'd3, 4'h3);
    send(16'hFFFF, 4'd0,  2'd0, 4'h4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 1);
    end
    @(posedge clk); #1;
    idle(2);
    send(16'h7FFF, 4'd15, 2'd2, 4'h6);
    send(16'hFFFF, 4'd8,  2'd1, 4'h7);
    send(16'hFF00, 4'd8,  2'd2, 4'h8);
    idle(6);
    out_ready = 1'b0;
    send(16'hA5A5, 4'd3, 2'd3, 4'h9);
    send(16'h0F0F, 4'd2, 2'd0, 4'hA);
    send(16'hF000, 4'd12, 2'd2, 4'hB);
    send(16'h1234, 4'd1, 2'd1, 4'hC);
    in_valid = 1'b0;
    held_d = out_data;
    held_t = out_tag;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(held_d));
      chk("stall_tag", 32'(out_tag), 32'(held_t));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(8);
    chk("stall_drain", 32'(q.size()), 0);
    send(16'h00FF, 4'd1, 2'd0, 4'hD);
    send(16'h0F00, 4'd2, 2'd1, 4'hE);
    send(16'h8001, 4'd3, 2'd3, 4'hF);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_tag", 32'(out_tag), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = W'($urandom);
      in_shamt  = SW'($urandom_range(0, 15));
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = TW'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(10);
    chk("rand_drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
